mult_div_unit: RTL and testbench

//   Multicycle signed multiply/divide unit for MULT/DIV instructions. Owns the Hi and Lo

---
 rtl/mult_div_unit.sv | 158 +++++++++++++++
 tb/tb_mult_div_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit owning the Hi/Lo registers.
// Radix-2 Booth multiply and restoring divide, one step per clock, 32 steps per operation.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {StIdle, StMult, StDiv, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH:0]   prod_q, prod_d;   // {P, Q, q-1}
    logic [WIDTH-1:0]   opnd_q, opnd_d;   // Booth multiplicand or divisor magnitude
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               zero_q, zero_d;

    logic [WIDTH:0]     booth_p;
    logic [WIDTH:0]     booth_m;
    logic [WIDTH:0]     booth_sum;
    logic [2*WIDTH:0]   booth_nx;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   rem_nx;
    logic [WIDTH-1:0]   quo_nx;
    logic               last_step;

    // P is sign-extended to 33 bits so adding/subtracting -2^31 cannot overflow.
    always_comb begin
        booth_p = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
        booth_m = {opnd_q[WIDTH-1], opnd_q};
        unique case (prod_q[1:0])
            2'b01:   booth_sum = booth_p + booth_m;
            2'b10:   booth_sum = booth_p - booth_m;
            default: booth_sum = booth_p;
        endcase
        booth_nx = {booth_sum, prod_q[WIDTH:1]};
    end

    always_comb begin
        div_sh   = {rem_q, quo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd_q};
        rem_nx   = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
        quo_nx   = {quo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end

    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        opnd_d  = opnd_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        zero_d  = zero_q;
        unique case (state_q)
            StIdle: begin
                if (start_mult) begin
                    prod_d  = {{WIDTH{1'b0}}, a, 1'b0};
                    opnd_d  = b;
                    cnt_d   = '0;
                    state_d = StMult;
                end else if (start_div && (b != '0)) begin
                    rem_d   = '0;
                    quo_d   = a[WIDTH-1] ? -a : a;
                    opnd_d  = b[WIDTH-1] ? -b : b;
                    negq_d  = a[WIDTH-1] ^ b[WIDTH-1];
                    negr_d  = a[WIDTH-1];
                    cnt_d   = '0;
                    state_d = StDiv;
                end else if (start_div) begin
                    zero_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StMult: begin
                prod_d = booth_nx;
                cnt_d  = cnt_q + 1'b1;
                if (last_step) begin
                    hi_d    = booth_nx[2*WIDTH:WIDTH+1];
                    lo_d    = booth_nx[WIDTH:1];
                    state_d = StDone;
                end
            end
            StDiv: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    lo_d    = negq_q ? -quo_nx : quo_nx;
                    hi_d    = negr_q ? -rem_nx : rem_nx;
                    state_d = StDone;
                end
            end
            StDone: begin
                zero_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            prod_q  <= '0;
            opnd_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            opnd_q  <= opnd_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            zero_q  <= zero_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q == StMult) || (state_q == StDiv);
    assign done     = (state_q == StDone);
    assign div_zero = (state_q == StDone) && zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: cycle-level behavioural model plus directed literal checks
// and a randomized phase with starts, operand noise and resets arriving at any time.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    mult_div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted op takes 32 cycles of busy, results land as done rises.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_done, m_dz;
    int          left;

    task automatic compute(input bit is_mult, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] rh, output logic [31:0] rl);
        longint sx, sy, r;
        longint q;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (is_mult) begin
            r  = sx * sy;
            rh = r[63:32];
            rl = r[31:0];
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            rh = r[31:0];
            rl = q[31:0];
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_hi = 0; m_lo = 0; left = 0; m_done = 0; m_dz = 0;
        end else if (left > 0) begin
            left--;
            if (left == 0) begin
                m_hi = p_hi; m_lo = p_lo; m_done = 1;
            end
        end else if (m_done) begin
            m_done = 0; m_dz = 0;
        end else if (start_mult) begin
            compute(1'b1, a, b, p_hi, p_lo);
            left = 32;
        end else if (start_div && b == 0) begin
            m_done = 1; m_dz = 1;
        end else if (start_div) begin
            compute(1'b0, a, b, p_hi, p_lo);
            left = 32;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'b0, busy}, {31'b0, left > 0});
            check("done", {31'b0, done}, {31'b0, m_done});
            check("div_zero", {31'b0, div_zero}, {31'b0, m_dz});
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic start(input bit sm, input bit sd, input logic [31:0] x, input logic [31:0] y);
        start_mult = sm; start_div = sd; a = x; b = y;
        @(posedge clk); #1;
        start_mult = 0; start_div = 0; a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(output int edges, output int bcnt);
        edges = 0; bcnt = 0;
        while (!done && edges < 40) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            edges++;
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: done not seen within %0d cycles", edges);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_op(input bit sm, input bit sd, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input string nm);
        int e, bc;
        start(sm, sd, x, y);
        wait_done(e, bc);
        check({nm, "_hi"}, hi, eh);
        check({nm, "_lo"}, lo, el);
        check({nm, "_model_hi"}, m_hi, eh);
        check({nm, "_model_lo"}, m_lo, el);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hffff_ffff;
            3: return 32'h1;
            4: return 32'h7fff_ffff;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int e, bc;
        bit saw;
        reset = 1; start_mult = 0; start_div = 0; a = 0; b = 0;
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        reset = 0;

        // Reset held two cycles in the middle of a multiply.
        start(1, 0, 32'd7, 32'hffff_fffd);
        repeat (5) @(posedge clk);
        #1 reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);

        // 7 * -3 with latency and busy-length checks.
        start(1, 0, 32'd7, 32'hffff_fffd);
        wait_done(e, bc);
        check("mul_latency", e, 32);
        check("mul_busy_cycles", bc, 32);
        check("mul7_hi", hi, 32'hffff_ffff);
        check("mul7_lo", lo, 32'hffff_ffeb);

        run_op(1, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, "mulmin");
        run_op(1, 0, 32'hffff_ffff, 32'hffff_ffff, 32'h0, 32'h1, "mulm1");
        run_op(0, 1, 32'd7, 32'hffff_fffe, 32'h1, 32'hffff_fffd, "div7");
        run_op(0, 1, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 32'hffff_fffd, "divm7");
        run_op(0, 1, 32'h8000_0000, 32'hffff_ffff, 32'h0, 32'h8000_0000, "divwrap");

        // Divide by zero keeps a preloaded Hi/Lo.
        run_op(1, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, "preload");
        start(0, 1, 32'd1234, 32'd0);
        check("dz_done", {31'b0, done}, 1);
        check("dz_flag", {31'b0, div_zero}, 1);
        check("dz_busy", {31'b0, busy}, 0);
        check("dz_hi", hi, 32'h4000_0000);
        check("dz_lo", lo, 32'h0);
        @(posedge clk); #1;
        check("dz_done_clear", {31'b0, done}, 0);

        // start_div pulsed mid-multiply is ignored.
        start(1, 0, 32'd100, 32'hffff_ff9c);
        repeat (9) @(posedge clk);
        #1 start_div = 1; a = 32'd50; b = 32'd3;
        @(posedge clk); #1 start_div = 0;
        wait_done(e, bc);
        check("ign_hi", hi, 32'hffff_ffff);
        check("ign_lo", lo, 32'hffff_d8f0);

        run_op(1, 1, 32'd6, 32'd9, 32'h0, 32'd54, "both");

        // Reset during a divide: no done, Hi/Lo cleared.
        start(0, 1, 32'd1000, 32'd7);
        repeat (14) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        check("rdiv_hi", hi, 0);
        check("rdiv_lo", lo, 0);
        check("rdiv_busy", {31'b0, busy}, 0);
        saw = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw = 1;
        end
        check("rdiv_no_done", {31'b0, saw}, 0);

        // Random phase: the per-cycle compare against the model does the checking.
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 599) == 0);
            start_mult = ($urandom_range(0, 9) == 0);
            start_div  = ($urandom_range(0, 7) == 0);
            a          = pick();
            b          = pick();
            @(posedge clk); #1;
        end
        reset = 0; start_mult = 0; start_div = 0;
        repeat (40) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
